// File: rtl/run_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : run_ctrl_if
//  Description : Handshake bundle between the top-level req/done pins, the
//                instruction decoder and the run_ctrl sequencer.
//                master : top-level / decoder side (drives req, start_addr,
//                         halt; observes status)
//                slave  : run_ctrl side
//  Signals     : req          start request (1-cycle pulse is enough)
//                start_addr   [D-1:0]  PC value for the run
//                halt         decoder flags HALT in the executing slot
//                pc_init      1-cycle strobe loading the PC
//                pc_init_val  [D-1:0]  latched start address
//                run_en       PC advance / write enable
//                busy         high in INIT, RUN and DRAIN
//                done         run complete, held until the next start
//                cycle_cnt    [CW-1:0] run_en-high cycles of the last run
//                timeout      last run was ended by the watchdog
//  Revision    : 1.0 - initial release
// ============================================================================
interface run_ctrl_if #(
  parameter int D  = 12,
  parameter int CW = 16
);
  logic          req;
  logic [D-1:0]  start_addr;
  logic          halt;
  logic          pc_init;
  logic [D-1:0]  pc_init_val;
  logic          run_en;
  logic          busy;
  logic          done;
  logic [CW-1:0] cycle_cnt;
  logic          timeout;

  modport master (
    output req, start_addr, halt,
    input  pc_init, pc_init_val, run_en, busy, done, cycle_cnt, timeout
  );

  modport slave (
    input  req, start_addr, halt,
    output pc_init, pc_init_val, run_en, busy, done, cycle_cnt, timeout
  );
endinterface
`default_nettype wire

// File: rtl/run_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : run_ctrl
//  Description : Program-run sequencer. Accepts a start request, strobes the
//                PC load, gates fetch/execute until the decoder reports HALT,
//                drains one cycle for the final writeback, then holds done.
//                Counts run_en-high cycles (saturating).
//  Ports       : clk    system clock (rising edge)
//                reset  synchronous, active-high
//                bus    run_ctrl_if.slave (req, start_addr, halt in;
//                       pc_init, pc_init_val, run_en, busy, done,
//                       cycle_cnt, timeout out)
//  Options     : RUN_WATCHDOG_EN - when defined, a run that reaches TIMEOUT
//                run cycles without HALT is forced into DRAIN and flagged
//                with timeout. Undefined: no comparator, timeout tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module run_ctrl #(
  parameter int D       = 12,
  parameter int CW      = 16,
  parameter int TIMEOUT = 4000
) (
  input  logic       clk,
  input  logic       reset,
  run_ctrl_if.slave  bus
);

  localparam logic [2:0] c_idle  = 3'd0;
  localparam logic [2:0] c_init  = 3'd1;
  localparam logic [2:0] c_run   = 3'd2;
  localparam logic [2:0] c_drain = 3'd3;
  localparam logic [2:0] c_done  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [D-1:0]  pc_init_val_q, pc_init_val_d;
  logic [CW-1:0] cycle_cnt_q, cycle_cnt_d;
  logic          w_accept;
  logic          w_wd_expire;

  // A start is only taken when no run is in flight.
  assign w_accept = bus.req && ((state_q == c_idle) || (state_q == c_done));

`ifdef RUN_WATCHDOG_EN
  localparam logic [CW-1:0] c_limit = CW'(TIMEOUT - 1);
  logic timeout_q, timeout_d;

  // cycle_cnt lags the run by one, so matching TIMEOUT-1 ends the run after
  // exactly TIMEOUT run_en cycles.
  assign w_wd_expire = (state_q == c_run) && (cycle_cnt_q == c_limit);
`else
  logic unused_timeout_param;

  assign w_wd_expire          = 1'b0;
  assign unused_timeout_param = (TIMEOUT != 0);
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= c_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      c_idle:  if (bus.req) state_d = c_init;
      c_init:  state_d = c_run;
      c_run:   if (bus.halt || w_wd_expire) state_d = c_drain;
      c_drain: state_d = c_done;
      c_done:  if (bus.req) state_d = c_init;
      default: state_d = c_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output decode (Moore, from registered state)
  // --------------------------------------------------------------------------
  always_comb begin
    bus.pc_init = (state_q == c_init);
    bus.run_en  = (state_q == c_run);
    bus.busy    = (state_q == c_init) || (state_q == c_run) || (state_q == c_drain);
    bus.done    = (state_q == c_done);
  end

  // --------------------------------------------------------------------------
  // Run datapath: start address latch, cycle counter, watchdog flag
  // --------------------------------------------------------------------------
  always_comb begin
    pc_init_val_d = pc_init_val_q;
    cycle_cnt_d   = cycle_cnt_q;
    if (w_accept) begin
      // Clearing on acceptance makes the fresh values visible during INIT.
      pc_init_val_d = bus.start_addr;
      cycle_cnt_d   = '0;
    end else if ((state_q == c_run) && (cycle_cnt_q != '1)) begin
      cycle_cnt_d = cycle_cnt_q + CW'(1);
    end
  end

`ifdef RUN_WATCHDOG_EN
  always_comb begin
    timeout_d = timeout_q;
    if (w_accept) begin
      timeout_d = 1'b0;
    end else if (w_wd_expire && !bus.halt) begin
      // HALT in the same cycle as the limit is a normal finish.
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign bus.timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_init_val_q <= '0;
      cycle_cnt_q   <= '0;
    end else begin
      pc_init_val_q <= pc_init_val_d;
      cycle_cnt_q   <= cycle_cnt_d;
    end
  end

  assign bus.pc_init_val = pc_init_val_q;
  assign bus.cycle_cnt   = cycle_cnt_q;

endmodule
`default_nettype wire
